l1_i_data_array: RTL and testbench
==================================

// Module: l1_i_data_array
// PURPOSE
// - Data store of the L1 instruction cache: 2-way set-associative, 2**INUM sets, 64-byte (L21BUS-bit) lines.
// - Sits beside the L1-I tag array and controller.
// - Controller supplies set index, byte offset, selected way and a refill strobe.
// - Refill writes one full line from L2; every cycle returns one 32-bit instruction word to the core.
// PARAMETERS
// - TNUM    21         tag width (informational; tags live in the tag array)
// - INUM    26-TNUM    set-index width (default 5 -> 32 sets)
// - L1CBUS  32         core-side read word width
// - L21BUS  512        L2->L1 line width; must equal 64*8
// PORTS
// - clk              in   1       single clock, rising edge
// - nrst             in   1       asynchronous, active-high reset (asserted = 1)
// - index_C_L1       in   INUM    set index (address[6 +: INUM])
// - offset           in   6       byte offset in line (address[5:0])
// - read_data_L2_L1  in   L21BUS  refill line from L2
// - refill           in   1       1 = write line this cycle
// - way              in   1       way select for both read and refill
// - read_data_L1_C   out  L1CBUS  instruction word to core
// BEHAVIOUR
// - Storage: mem[way][set] of L21BUS bits; 2 x 2**INUM lines.
// - Word select: w = offset[5:2]; word w = line[32*w +: 32]. offset[1:0] ignored (word aligned).
// - Reset (nrst=1, async): read_data_L1_C -> 0 immediately. Array clearing: see CONFIGURATION.
//   Reset asserted mid-refill: that write is dropped.
// - Refill: on posedge with refill=1, mem[way][index_C_L1] <= read_data_L2_L1 (whole line).
//   Refill always overwrites; no valid/dirty state here.
// - Read: output registered, 1-cycle latency.
//   On each posedge, read_data_L1_C <= word w of mem[way][index_C_L1].
// - Refill bypass (same edge): on an edge with refill=1, output takes word w of read_data_L2_L1, not old array data.
//   The core sees the new line's word one cycle after the refill edge.
// - Other way and other sets are unaffected by a refill.
// - Inputs held stable: output holds the same word. way/index/offset may change every cycle; no handshake.
// - Out-of-range inputs are not possible: index width exactly INUM, way 1 bit.
// CONFIGURATION
// - Macro L1I_DATA_ARRAY_RESET_CLEAR_EN
//   - Defined: reset also clears every line of both ways to 0; after reset any read returns 0 until refilled.
//   - Undefined: reset clears only read_data_L1_C; array contents are retained/undefined (RAM-inferable).
// TESTING
// 1. Reset: nrst=1 for 5 cycles -> read_data_L1_C=0 at once, stays 0 until first clocked read after release.
// 2. Refill way0: index=3, offset=0x08, refill=1, line word2=0xDEADBEEF
//    -> next cycle read_data_L1_C=0xDEADBEEF (bypass); later read with refill=0 returns same.
// 3. Fill all 32 sets of way0 and way1 with random lines; read back every set/way at offsets 0x00, 0x3C
//    -> exact words 0 and 15 of each line.
// 4. Way isolation: refill set 5 way1 with all-0xA5 line after way0 holds 0x11111111
//    -> way0 read still 0x11111111, way1 read 0xA5A5A5A5.
// 5. Replace: refill set 7 way0 twice with different lines -> reads return only the second line.
// 6. Offset[1:0]=3 vs 0 on same word -> identical output.
//    With L1I_DATA_ARRAY_RESET_CLEAR_EN: reset after fills -> all reads 0.

Source files
------------

// File: rtl/l1_i_data_array.sv
// l1_i_data_array
//   Data store of the L1 instruction cache. It is 2-way set-associative with
//   2**INUM sets of one L21BUS-bit (64-byte) line each. Tags are kept in the
//   separate tag array; this block holds only line data.
//
//   A refill writes one whole line from L2 into mem[way][index_C_L1].
//   Every cycle the block returns one registered 32-bit instruction word.
//   On a refill edge the returned word comes straight from the incoming line,
//   so the core sees the new data one cycle after the refill.
//
// Ports
//   clk              in   1       rising-edge clock
//   nrst             in   1       asynchronous reset, active HIGH (1 = in reset)
//   index_C_L1       in   INUM    set index (address[6 +: INUM])
//   offset           in   6       byte offset in line; only [5:2] selects a word
//   read_data_L2_L1  in   L21BUS  refill line from L2
//   refill           in   1       write the line at this edge
//   way              in   1       way select, used for both read and refill
//   read_data_L1_C   out  L1CBUS  instruction word to the core, 1-cycle latency
//
// Configuration
//   L1I_DATA_ARRAY_RESET_CLEAR_EN
//     Defined:   reset also zeroes every line of both ways.
//     Undefined: reset clears only the output register. Array contents are
//                kept as they are, so the array maps onto plain RAM.
module l1_i_data_array #(
    parameter int TNUM   = 21,
    parameter int INUM   = 26 - TNUM,
    parameter int L1CBUS = 32,
    parameter int L21BUS = 512
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [INUM-1:0]   index_C_L1,
    input  logic [5:0]        offset,
    input  logic [L21BUS-1:0] read_data_L2_L1,
    input  logic              refill,
    input  logic              way,
    output logic [L1CBUS-1:0] read_data_L1_C
);
    localparam int NWAYS = 2;
    localparam int NSETS = 1 << INUM;

    // The tag width is not used in the data path. Byte offset bits [1:0] are
    // also ignored, because fetches are word aligned.
    logic [TNUM-1:0] unused_tag_w;
    logic [1:0]      unused_byte_sel;
    assign unused_tag_w    = '0;
    assign unused_byte_sel = offset[1:0];

    logic [3:0]                   word_sel;
    logic [NWAYS-1:0][L21BUS-1:0] way_line;
    logic [L21BUS-1:0]            rd_line;

    assign word_sel = offset[5:2];

    genvar g;
    generate
        for (g = 0; g < NWAYS; g++) begin : g_way
            logic [L21BUS-1:0] mem [NSETS];
            logic              we;

            assign we = refill && (way == g[0]);

`ifdef L1I_DATA_ARRAY_RESET_CLEAR_EN
            always_ff @(posedge clk or posedge nrst) begin
                if (nrst) begin
                    for (int s = 0; s < NSETS; s++) mem[s] <= '0;
                end else if (we) begin
                    mem[index_C_L1] <= read_data_L2_L1;
                end
            end
`else
            // This block has no reset, so the array can map onto RAM.
            // Gating the write with nrst drops a refill that lands while
            // reset is asserted.
            always_ff @(posedge clk) begin
                if (we && !nrst) mem[index_C_L1] <= read_data_L2_L1;
            end
`endif

            assign way_line[g] = mem[index_C_L1];
        end
    endgenerate

    // Bypass: on a refill edge the array still holds the old line, so the
    // word is taken from the incoming line instead.
    assign rd_line = refill ? read_data_L2_L1 : way_line[way];

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) read_data_L1_C <= '0;
        else      read_data_L1_C <= rd_line[L1CBUS*word_sel +: L1CBUS];
    end

endmodule

// File: tb/tb_l1_i_data_array.sv
module tb_l1_i_data_array;
    localparam int INUM  = 5;
    localparam int NSETS = 1 << INUM;

    logic            clk = 1'b0;
    logic            nrst;
    logic [INUM-1:0] index_C_L1;
    logic [5:0]      offset;
    logic [511:0]    read_data_L2_L1;
    logic            refill;
    logic            way;
    logic [31:0]     read_data_L1_C;

    int checks = 0;
    int errors = 0;

    logic [511:0] model [2][NSETS];

    l1_i_data_array #(.TNUM(21), .INUM(INUM), .L1CBUS(32), .L21BUS(512)) dut (
        .clk             (clk),
        .nrst            (nrst),
        .index_C_L1      (index_C_L1),
        .offset          (offset),
        .read_data_L2_L1 (read_data_L2_L1),
        .refill          (refill),
        .way             (way),
        .read_data_L1_C  (read_data_L1_C)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge. The output is sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] fill_line(input logic [31:0] w);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[32*i +: 32] = w;
        return l;
    endfunction

    task automatic do_refill(input logic wy, input int idx, input logic [511:0] l, input logic [5:0] off);
        way = wy; index_C_L1 = INUM'(idx); offset = off;
        read_data_L2_L1 = l; refill = 1'b1;
        step();
        refill = 1'b0;
        model[wy][idx] = l;
    endtask

    task automatic do_read(input string tag, input logic wy, input int idx, input logic [5:0] off,
                           input logic [31:0] exp);
        way = wy; index_C_L1 = INUM'(idx); offset = off; refill = 1'b0;
        read_data_L2_L1 = '1;
        step();
        check(tag, read_data_L1_C, exp);
    endtask

    initial begin
        logic [511:0] l;
        logic [511:0] la;
        logic [511:0] lb;
        logic [31:0]  wrd;

        nrst = 1'b1; refill = 1'b0; way = 1'b0; index_C_L1 = '0; offset = '0;
        read_data_L2_L1 = '0;

        // Reset drives the output to 0 at once, then holds it at 0.
        #1;
        check("rst_async", read_data_L1_C, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst_hold", read_data_L1_C, 32'h0);
        end
        nrst = 1'b0;
        #3;
        check("rst_release", read_data_L1_C, 32'h0);
        step();

        // Refill way0 set3. Word2 is DEADBEEF; the other words differ from it.
        for (int i = 0; i < 16; i++) l[32*i +: 32] = 32'h1000_0000 + i;
        l[64 +: 32] = 32'hDEADBEEF;
        do_refill(1'b0, 3, l, 6'h08);
        check("bypass_w2", read_data_L1_C, 32'hDEADBEEF);
        do_read("read_w2", 1'b0, 3, 6'h08, 32'hDEADBEEF);

        // Fill both ways of every set with random lines, then read words 0 and 15.
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < NSETS; s++) begin
                for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom;
                do_refill(w[0], s, l, 6'h00);
            end
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < NSETS; s++) begin
                la = model[w][s];
                do_read("sweep_w0", w[0], s, 6'h00, la[31:0]);
                do_read("sweep_w15", w[0], s, 6'h3C, la[511:480]);
            end

        // A refill of one way leaves the other way unchanged.
        do_refill(1'b0, 5, fill_line(32'h11111111), 6'h00);
        do_refill(1'b1, 5, fill_line(32'hA5A5A5A5), 6'h00);
        check("iso_bypass", read_data_L1_C, 32'hA5A5A5A5);
        do_read("iso_way0", 1'b0, 5, 6'h14, 32'h11111111);
        do_read("iso_way1", 1'b1, 5, 6'h14, 32'hA5A5A5A5);
        do_read("iso_set4", 1'b0, 4, 6'h00, model[0][4][31:0]);

        // Refilling set7 way0 twice leaves only the second line visible.
        for (int i = 0; i < 16; i++) begin
            la[32*i +: 32] = 32'hAAAA_0000 + i;
            lb[32*i +: 32] = 32'hBBBB_0000 + i;
        end
        do_refill(1'b0, 7, la, 6'h00);
        do_refill(1'b0, 7, lb, 6'h24);
        check("repl_bypass", read_data_L1_C, 32'hBBBB0009);
        do_read("repl_w0", 1'b0, 7, 6'h00, 32'hBBBB0000);
        do_read("repl_w9", 1'b0, 7, 6'h24, 32'hBBBB0009);
        do_read("repl_w15", 1'b0, 7, 6'h3C, 32'hBBBB000F);

        // offset[1:0] does not change which word is returned.
        do_read("offs_lo0", 1'b0, 7, 6'h10, 32'hBBBB0004);
        do_read("offs_lo3", 1'b0, 7, 6'h13, 32'hBBBB0004);
        do_read("offs_lo1", 1'b0, 7, 6'h2D, 32'hBBBB000B);

        // A refill that lands while reset is asserted is dropped.
        do_refill(1'b1, 9, fill_line(32'hC0C0C0C0), 6'h00);
        way = 1'b1; index_C_L1 = INUM'(9); offset = 6'h00;
        read_data_L2_L1 = fill_line(32'hD1D1D1D1); refill = 1'b1;
        nrst = 1'b1;
        #1;
        check("midrst_out", read_data_L1_C, 32'h0);
        step();
        check("midrst_hold", read_data_L1_C, 32'h0);
        refill = 1'b0; nrst = 1'b0;
`ifdef L1I_DATA_ARRAY_RESET_CLEAR_EN
        wrd = 32'h0;
`else
        wrd = 32'hC0C0C0C0;
`endif
        do_read("midrst_drop", 1'b1, 9, 6'h00, wrd);

`ifdef L1I_DATA_ARRAY_RESET_CLEAR_EN
        // With clearing enabled, reset zeroes data that was filled earlier.
        do_refill(1'b0, 3, fill_line(32'h12345678), 6'h00);
        nrst = 1'b1;
        step();
        nrst = 1'b0;
        do_read("clr_s3w0", 1'b0, 3, 6'h00, 32'h0);
        do_read("clr_s5w1", 1'b1, 5, 6'h3C, 32'h0);
        do_read("clr_s7w0", 1'b0, 7, 6'h24, 32'h0);
        do_read("clr_s31w1", 1'b1, 31, 6'h08, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
